madgwick_wb_sequencer: RTL and testbench

Wishbone master that runs the Madgwick peripheral (madgwick_top) one IMU sample at a time with no CPU involvement. It accepts a six-axis sample on a valid/ready input and writes it to the sensor registers. It then sets start, polls done, clears start, reads the four quaternion words and presents them on a valid/ready output. It sits between the IMU capture logic and the madgwick_top slave port, in place of software polling.

---
 rtl/madgwick_seq_pkg.sv | 57 +++++
 rtl/madgwick_wb_sequencer_if.sv | 23 ++
 rtl/madgwick_wb_master_port.sv | 83 ++++++++
 rtl/madgwick_wb_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_madgwick_wb_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/madgwick_seq_pkg.sv
// rtl/madgwick_seq_pkg.sv - Madgwick sequencer register map, CTRL encoding and FSM states
package madgwick_seq_pkg;

    localparam int ADR_W = 6;

    localparam logic [ADR_W-1:0] ADR_CTRL = 6'h00;
    localparam logic [ADR_W-1:0] ADR_A_X  = 6'h01;
    localparam logic [ADR_W-1:0] ADR_A_Y  = 6'h05;
    localparam logic [ADR_W-1:0] ADR_A_Z  = 6'h09;
    localparam logic [ADR_W-1:0] ADR_W_X  = 6'h0D;
    localparam logic [ADR_W-1:0] ADR_W_Y  = 6'h11;
    localparam logic [ADR_W-1:0] ADR_W_Z  = 6'h15;
    localparam logic [ADR_W-1:0] ADR_Q_W  = 6'h19;
    localparam logic [ADR_W-1:0] ADR_Q_X  = 6'h1D;
    localparam logic [ADR_W-1:0] ADR_Q_Y  = 6'h21;
    localparam logic [ADR_W-1:0] ADR_Q_Z  = 6'h25;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_START_BIT  = 1;
    localparam int CTRL_DONE_BIT   = 2;

    // 0x01: enable only; 0x03: enable + start
    localparam logic [2:0] CTRL_IDLE = 3'(1 << CTRL_ENABLE_BIT);
    localparam logic [2:0] CTRL_RUN  = 3'((1 << CTRL_ENABLE_BIT) | (1 << CTRL_START_BIT));

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WAIT_SAMPLE,
        ST_WR_SENS,
        ST_WR_START,
        ST_POLL,
        ST_CLR_START,
        ST_RD_Q,
        ST_OUT
    } seq_state_t;

    function automatic logic [ADR_W-1:0] sens_adr(input logic [2:0] idx);
        case (idx)
            3'd0:    return ADR_A_X;
            3'd1:    return ADR_A_Y;
            3'd2:    return ADR_A_Z;
            3'd3:    return ADR_W_X;
            3'd4:    return ADR_W_Y;
            default: return ADR_W_Z;
        endcase
    endfunction

    function automatic logic [ADR_W-1:0] q_adr(input logic [1:0] idx);
        case (idx)
            2'd0:    return ADR_Q_W;
            2'd1:    return ADR_Q_X;
            2'd2:    return ADR_Q_Y;
            default: return ADR_Q_Z;
        endcase
    endfunction

endpackage

// File: rtl/madgwick_wb_sequencer_if.sv
// rtl/madgwick_wb_sequencer_if.sv - Wishbone bus between the sequencer (master) and madgwick_top (slave)
// Signals: adr, dat_m2s (write data), dat_s2m (read data), we, stb, cyc, ack.
interface madgwick_wb_sequencer_if #(
    parameter int DATA_W = 32
);
    logic [5:0]        adr;
    logic [DATA_W-1:0] dat_m2s;
    logic [DATA_W-1:0] dat_s2m;
    logic              we;
    logic              stb;
    logic              cyc;
    logic              ack;

    modport master (
        output adr, dat_m2s, we, stb, cyc,
        input  dat_s2m, ack
    );

    modport slave (
        input  adr, dat_m2s, we, stb, cyc,
        output dat_s2m, ack
    );
endinterface

// File: rtl/madgwick_wb_master_port.sv
// rtl/madgwick_wb_master_port.sv - single Wishbone transaction engine with idle gap and ack timeout
// Ports: clk, rst; req_i/we_i/adr_i/wdat_i request a transaction; done_o (one-cycle pulse,
// rdat_o valid with it) or timeout_o (one-cycle pulse) ends it; wb drives the bus.
module madgwick_wb_master_port
    import madgwick_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [ADR_W-1:0]         adr_i,
    input  logic [DATA_W-1:0]        wdat_i,
    output logic                     done_o,
    output logic [DATA_W-1:0]        rdat_o,
    output logic                     timeout_o,
    madgwick_wb_sequencer_if.master  wb
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic              stb_q;
    logic              we_q;
    logic [ADR_W-1:0]  adr_q;
    logic [DATA_W-1:0] dat_q;
    logic [DATA_W-1:0] rdat_q;
    logic [TW-1:0]     tmr_q;
    logic              gap_q;
    logic              done_q;
    logic              timeout_q;

    // gap_q is set on the same edge as done/timeout, so the requester still
    // asserting req during its completion cycle cannot start a back-to-back strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            rdat_q    <= '0;
            tmr_q     <= '0;
            gap_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            gap_q     <= 1'b0;
            if (stb_q) begin
                if (wb.ack) begin
                    stb_q  <= 1'b0;
                    we_q   <= 1'b0;
                    rdat_q <= wb.dat_s2m;
                    done_q <= 1'b1;
                    gap_q  <= 1'b1;
                end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                    stb_q     <= 1'b0;
                    we_q      <= 1'b0;
                    timeout_q <= 1'b1;
                    gap_q     <= 1'b1;
                end else begin
                    tmr_q <= tmr_q + 1'b1;
                end
            end else if (req_i && !gap_q) begin
                stb_q <= 1'b1;
                we_q  <= we_i;
                adr_q <= adr_i;
                dat_q <= wdat_i;
                tmr_q <= '0;
            end
        end
    end

    assign wb.cyc     = stb_q;
    assign wb.stb     = stb_q;
    assign wb.we      = we_q;
    assign wb.adr     = adr_q;
    assign wb.dat_m2s = dat_q;
    assign done_o     = done_q;
    assign rdat_o     = rdat_q;
    assign timeout_o  = timeout_q;
endmodule

// File: rtl/madgwick_wb_sequencer.sv
// rtl/madgwick_wb_sequencer.sv - runs madgwick_top over Wishbone one IMU sample at a time
// Ports: clk, rst; en_i; sample valid/ready with a_*/w_* words; q valid/ready with q_* words;
// wb (master modport); busy_o (step in progress); err_o (ack or poll timeout pulse).
module madgwick_wb_sequencer
    import madgwick_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 64,
    parameter int POLL_MAX    = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     sample_valid_i,
    output logic                     sample_ready_o,
    input  logic [DATA_W-1:0]        a_x_i,
    input  logic [DATA_W-1:0]        a_y_i,
    input  logic [DATA_W-1:0]        a_z_i,
    input  logic [DATA_W-1:0]        w_x_i,
    input  logic [DATA_W-1:0]        w_y_i,
    input  logic [DATA_W-1:0]        w_z_i,
    output logic                     q_valid_o,
    input  logic                     q_ready_i,
    output logic [DATA_W-1:0]        q_w_o,
    output logic [DATA_W-1:0]        q_x_o,
    output logic [DATA_W-1:0]        q_y_o,
    output logic [DATA_W-1:0]        q_z_o,
    madgwick_wb_sequencer_if.master  wb,
    output logic                     busy_o,
    output logic                     err_o
);
    localparam int PW = $clog2(POLL_MAX + 1);

    seq_state_t        state_q, state_d;
    logic [2:0]        idx_q;
    logic [PW-1:0]     poll_cnt_q;
    logic              abort_q;
    logic              err_q;
    logic [DATA_W-1:0] s_q [6];
    logic [DATA_W-1:0] q_q [4];

    logic              bus_req, bus_we, bus_done, bus_timeout;
    logic [ADR_W-1:0]  bus_adr;
    logic [DATA_W-1:0] bus_wdat, bus_rdat;
    logic              accept, poll_last, poll_hit;

    madgwick_wb_master_port #(
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_port (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus_req),
        .we_i      (bus_we),
        .adr_i     (bus_adr),
        .wdat_i    (bus_wdat),
        .done_o    (bus_done),
        .rdat_o    (bus_rdat),
        .timeout_o (bus_timeout),
        .wb        (wb)
    );

    assign accept    = (state_q == ST_WAIT_SAMPLE) && en_i && sample_valid_i;
    assign poll_hit  = bus_rdat[CTRL_DONE_BIT];
    assign poll_last = (poll_cnt_q == PW'(POLL_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus_timeout) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT:        if (bus_done) state_d = ST_WAIT_SAMPLE;
                ST_WAIT_SAMPLE: if (accept) state_d = ST_WR_SENS;
                ST_WR_SENS:     if (bus_done && idx_q == 3'd5) state_d = ST_WR_START;
                ST_WR_START:    if (bus_done) state_d = ST_POLL;
                ST_POLL:        if (bus_done && (poll_hit || poll_last)) state_d = ST_CLR_START;
                ST_CLR_START:   if (bus_done) state_d = abort_q ? ST_WAIT_SAMPLE : ST_RD_Q;
                ST_RD_Q:        if (bus_done && idx_q == 3'd3) state_d = ST_OUT;
                ST_OUT:         if (q_ready_i) state_d = ST_WAIT_SAMPLE;
                default:        state_d = ST_INIT;
            endcase
        end
    end

    always_comb begin
        bus_req        = 1'b0;
        bus_we         = 1'b0;
        bus_adr        = ADR_CTRL;
        bus_wdat       = '0;
        sample_ready_o = 1'b0;
        q_valid_o      = 1'b0;
        busy_o         = 1'b1;
        case (state_q)
            ST_INIT: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_wdat = DATA_W'(CTRL_IDLE);
                busy_o   = 1'b0;
            end
            ST_WAIT_SAMPLE: begin
                sample_ready_o = en_i;
                busy_o         = 1'b0;
            end
            ST_WR_SENS: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_adr  = sens_adr(idx_q);
                bus_wdat = s_q[idx_q];
            end
            ST_WR_START: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_wdat = DATA_W'(CTRL_RUN);
            end
            ST_POLL:      bus_req = 1'b1;
            ST_CLR_START: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_wdat = DATA_W'(CTRL_IDLE);
            end
            ST_RD_Q: begin
                bus_req = 1'b1;
                bus_adr = q_adr(idx_q[1:0]);
            end
            ST_OUT:       q_valid_o = 1'b1;
            default:      busy_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            poll_cnt_q <= '0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < 6; i++) s_q[i] <= '0;
            for (int i = 0; i < 4; i++) q_q[i] <= '0;
        end else begin
            err_q <= bus_timeout;
            if (accept) begin
                s_q[0] <= a_x_i;
                s_q[1] <= a_y_i;
                s_q[2] <= a_z_i;
                s_q[3] <= w_x_i;
                s_q[4] <= w_y_i;
                s_q[5] <= w_z_i;
                idx_q  <= '0;
            end
            if (bus_done) begin
                case (state_q)
                    ST_WR_SENS:  idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                    ST_WR_START: begin
                        poll_cnt_q <= '0;
                        abort_q    <= 1'b0;
                    end
                    ST_POLL: begin
                        if (!poll_hit) begin
                            if (poll_last) begin
                                abort_q <= 1'b1;
                                err_q   <= 1'b1;
                            end else begin
                                poll_cnt_q <= poll_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_CLR_START: idx_q <= '0;
                    ST_RD_Q: begin
                        q_q[idx_q[1:0]] <= bus_rdat;
                        idx_q           <= idx_q + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign q_w_o = q_q[0];
    assign q_x_o = q_q[1];
    assign q_y_o = q_q[2];
    assign q_z_o = q_q[3];
    assign err_o = err_q;
endmodule

// File: tb/tb_madgwick_wb_sequencer.sv
// tb/tb_madgwick_wb_sequencer.sv - scoreboard bench for madgwick_wb_sequencer
module tb_madgwick_wb_sequencer;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_i = 1'b1;
    logic sample_valid_i = 1'b0;
    logic sample_ready_o;
    logic [DW-1:0] a_x_i = '0, a_y_i = '0, a_z_i = '0, w_x_i = '0, w_y_i = '0, w_z_i = '0;
    logic q_valid_o;
    logic q_ready_i = 1'b0;
    logic [DW-1:0] q_w_o, q_x_o, q_y_o, q_z_o;
    logic busy_o, err_o;

    madgwick_wb_sequencer_if #(.DATA_W(DW)) wb ();

    madgwick_wb_sequencer #(.DATA_W(DW), .ACK_TIMEOUT(64), .POLL_MAX(8)) dut (
        .clk(clk), .rst(rst), .en_i(en_i),
        .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
        .a_x_i(a_x_i), .a_y_i(a_y_i), .a_z_i(a_z_i),
        .w_x_i(w_x_i), .w_y_i(w_y_i), .w_z_i(w_z_i),
        .q_valid_o(q_valid_o), .q_ready_i(q_ready_i),
        .q_w_o(q_w_o), .q_x_o(q_x_o), .q_y_o(q_y_o), .q_z_o(q_z_o),
        .wb(wb), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [5:0] adr; logic [DW-1:0] dat; } txn_t;
    typedef struct { logic [DW-1:0] w, x, y, z; } quat_t;

    txn_t  exp_q[$];
    quat_t qexp_q[$];
    txn_t  e;
    quat_t qe;

    int passed = 0, total = 0;
    int poll_reads = 0, done_after = 5, withhold_adr = -1;
    int err_cnt = 0, qv_cnt = 0, proto_err = 0, run = 0, max_run = 0;
    logic acked_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    task automatic push_w(input logic [5:0] adr, input logic [DW-1:0] dat);
        txn_t t; t.we = 1'b1; t.adr = adr; t.dat = dat; exp_q.push_back(t);
    endtask

    task automatic push_r(input logic [5:0] adr);
        txn_t t; t.we = 1'b0; t.adr = adr; t.dat = '0; exp_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Wishbone slave model: acks one cycle after seeing stb, scoreboards each acked transaction.
    always @(negedge clk) begin
        if (rst) begin
            wb.ack = 1'b0; wb.dat_s2m = '0; acked_prev = 1'b0;
        end else begin
            if (acked_prev && wb.stb) proto_err++;
            acked_prev = 1'b0;
            if (wb.ack) begin
                wb.ack = 1'b0;
            end else if (wb.stb && wb.cyc && int'(wb.adr) != withhold_adr) begin
                wb.ack = 1'b1;
                acked_prev = 1'b1;
                if (wb.we && wb.adr == 6'h00) poll_reads = 0;
                if (!wb.we) begin
                    case (wb.adr)
                        6'h00: begin
                            poll_reads++;
                            wb.dat_s2m = (poll_reads > done_after) ? 32'h5 : 32'h3;
                        end
                        6'h19: wb.dat_s2m = 32'h4000;
                        6'h1D: wb.dat_s2m = 32'h0010;
                        6'h21: wb.dat_s2m = 32'hFFF0;
                        6'h25: wb.dat_s2m = 32'h0003;
                        default: wb.dat_s2m = 32'h0;
                    endcase
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_txn", 64'({wb.we, wb.adr}), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("txn_adr%0h", e.adr),
                          64'({wb.we, wb.adr, wb.we ? wb.dat_m2s : 32'h0}),
                          64'({e.we, e.adr, e.we ? e.dat : 32'h0}));
                end
            end
        end
    end

    // Result and protocol monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_o) err_cnt++;
            if (q_valid_o) qv_cnt++;
            if (q_valid_o && sample_ready_o) proto_err++;
            if (wb.stb) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (q_valid_o && q_ready_i) begin
                if (qexp_q.size() == 0) begin
                    check("unexpected_q", 64'(q_w_o), 64'hFFFF_FFFF_FFFF);
                end else begin
                    qe = qexp_q.pop_front();
                    check("q_w", 64'(q_w_o), 64'(qe.w));
                    check("q_x", 64'(q_x_o), 64'(qe.x));
                    check("q_y", 64'(q_y_o), 64'(qe.y));
                    check("q_z", 64'(q_z_o), 64'(qe.z));
                end
            end
        end
    end

    task automatic wait_ready(input string name, input int bound);
        int i;
        for (i = 0; i < bound && !sample_ready_o; i++) tick();
        check({name, "_ready_seen"}, 64'(sample_ready_o), 64'd1);
    endtask

    task automatic send_sample(input logic [DW-1:0] ax, ay, az, wx, wy, wz);
        wait_ready("send", 200);
        a_x_i = ax; a_y_i = ay; a_z_i = az; w_x_i = wx; w_y_i = wy; w_z_i = wz;
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        a_x_i = 32'hDEAD0001; a_y_i = 32'hDEAD0002; a_z_i = 32'hDEAD0003;
        w_x_i = 32'hDEAD0004; w_y_i = 32'hDEAD0005; w_z_i = 32'hDEAD0006;
        check("ready_low_after_accept", 64'(sample_ready_o), 64'd0);
    endtask

    task automatic push_sens(input logic [DW-1:0] ax, ay, az, wx, wy, wz);
        push_w(6'h01, ax); push_w(6'h05, ay); push_w(6'h09, az);
        push_w(6'h0D, wx); push_w(6'h11, wy); push_w(6'h15, wz);
    endtask

    initial begin
        quat_t qq;
        int i;
        // Reset and first enable write
        repeat (3) tick();
        check("reset_outputs_zero",
              64'(|{sample_ready_o, q_valid_o, q_w_o, q_x_o, q_y_o, q_z_o, wb.adr, wb.dat_m2s,
                    wb.we, wb.stb, wb.cyc, busy_o, err_o}), 64'd0);
        push_w(6'h00, 32'h1);
        rst = 1'b0;
        tick();
        check("ready_low_during_init", 64'(sample_ready_o), 64'd0);
        wait_ready("init", 20);
        check("init_write_before_ready", 64'(exp_q.size()), 64'd0);

        // Full step with done after 5 polls
        push_sens(32'h7B8, 32'h14A, 32'h0C4, 32'h3F1F, 32'h005C, 32'h3F54);
        push_w(6'h00, 32'h3);
        for (i = 0; i < 6; i++) push_r(6'h00);
        push_w(6'h00, 32'h1);
        push_r(6'h19); push_r(6'h1D); push_r(6'h21); push_r(6'h25);
        qq.w = 32'h4000; qq.x = 32'h0010; qq.y = 32'hFFF0; qq.z = 32'h0003;
        qexp_q.push_back(qq);
        send_sample(32'h7B8, 32'h14A, 32'h0C4, 32'h3F1F, 32'h005C, 32'h3F54);
        for (i = 0; i < 300 && !q_valid_o; i++) tick();
        check("q_valid_seen", 64'(q_valid_o), 64'd1);
        check("bus_done_before_q", 64'(exp_q.size()), 64'd0);
        for (i = 0; i < 10; i++) begin
            tick();
            check("q_hold_stable",
                  64'({q_valid_o, q_w_o, q_x_o, q_y_o, q_z_o, sample_ready_o} ===
                      {1'b1, 32'h4000, 32'h0010, 32'hFFF0, 32'h0003, 1'b0}), 64'd1);
        end
        q_ready_i = 1'b1;
        tick();
        q_ready_i = 1'b0;
        check("q_valid_drop", 64'(q_valid_o), 64'd0);
        wait_ready("after_out", 10);
        check("q_consumed", 64'(qexp_q.size()), 64'd0);

        // Poll timeout: done never set
        done_after = 1000; err_cnt = 0; qv_cnt = 0;
        push_sens(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66);
        push_w(6'h00, 32'h3);
        for (i = 0; i < 8; i++) push_r(6'h00);
        push_w(6'h00, 32'h1);
        send_sample(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66);
        wait_ready("poll_to", 300);
        check("poll_to_txns_done", 64'(exp_q.size()), 64'd0);
        check("poll_to_err_pulses", 64'(err_cnt), 64'd1);
        check("poll_to_no_q_valid", 64'(qv_cnt), 64'd0);

        // Ack withheld on A_Y write
        done_after = 5; err_cnt = 0; max_run = 0; withhold_adr = 6'h05;
        push_w(6'h01, 32'hA1);
        push_w(6'h00, 32'h1);
        send_sample(32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6);
        wait_ready("ack_to", 300);
        withhold_adr = -1;
        check("ack_to_txns_done", 64'(exp_q.size()), 64'd0);
        check("ack_to_err_pulses", 64'(err_cnt), 64'd1);
        check("ack_to_stb_cycles", 64'(max_run), 64'd64);

        // Reset during W_X write
        err_cnt = 0; withhold_adr = 6'h0D;
        push_sens(32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6);
        void'(exp_q.pop_back()); void'(exp_q.pop_back()); void'(exp_q.pop_back());
        send_sample(32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6);
        for (i = 0; i < 100 && !(wb.stb && wb.adr == 6'h0D); i++) tick();
        check("wx_strobe_seen", 64'(wb.stb && wb.adr == 6'h0D), 64'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_cyc_stb", 64'({wb.cyc, wb.stb}), 64'd0);
        check("rst_mid_outputs_zero",
              64'(|{sample_ready_o, q_valid_o, q_w_o, q_x_o, q_y_o, q_z_o, wb.adr, wb.dat_m2s,
                    wb.we, busy_o, err_o}), 64'd0);
        check("rst_mid_prior_txns", 64'(exp_q.size()), 64'd0);
        tick();
        withhold_adr = -1;
        push_w(6'h00, 32'h1);
        rst = 1'b0;
        wait_ready("after_rst", 20);
        check("after_rst_init_write", 64'(exp_q.size()), 64'd0);
        check("protocol_violations", 64'(proto_err), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
